// File: rtl/minilogix_cell_array.sv
// rtl/minilogix_cell_array.sv - programmable LUT cell array with serial config chain
//
// Purpose:
//   NUM_CELLS logic cells, each a LUT_K-input look-up table with an optional
//   output flip-flop. Every cell input selects from a routing pool made of
//   the external inputs followed by the registered cell outputs. The whole
//   configuration is loaded MSB-first through a single shift chain, and a
//   length counter reports whether the last completed load was exactly
//   CFG_BITS long.
//
// Ports:
//   clk       in   1          rising-edge clock
//   rst_n     in   1          asynchronous active-low reset
//   cfg_en    in   1          config shift enable; halts the core while high
//   cfg_data  in   1          serial config bit, sampled when cfg_en=1
//   ce        in   1          clock enable for the cell flip-flops
//   din       in   NUM_IN     external logic inputs
//   dout      out  NUM_CELLS  cell outputs
//   cfg_ok    out  1          last completed load had exactly CFG_BITS bits
//
// Per-cell field layout (cell i occupies chain[i*CW +: CW]):
//   [TT-1:0]                    truth table, indexed by {in_{K-1},...,in_0}
//   [TT]                        reg_en: 1 selects the flip-flop onto dout
//   [TT+1+j*SEL_W +: SEL_W]     pool select for LUT input j

module minilogix_cell_array #(
    parameter int NUM_IN    = 8,
    parameter int NUM_CELLS = 8,
    parameter int LUT_K     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_en,
    input  logic                 cfg_data,
    input  logic                 ce,
    input  logic [NUM_IN-1:0]    din,
    output logic [NUM_CELLS-1:0] dout,
    output logic                 cfg_ok
);

    localparam int POOL     = NUM_IN + NUM_CELLS;
    localparam int SEL_W    = $clog2(POOL);
    localparam int TT       = 1 << LUT_K;
    localparam int CW       = TT + 1 + LUT_K * SEL_W;
    localparam int CFG_BITS = NUM_CELLS * CW;
    // Counter must reach CFG_BITS+1 so that over-long loads stay distinguishable.
    localparam int CNT_W    = $clog2(CFG_BITS + 2);
    // Pool padded to the full select range so out-of-range selects read 0
    // without needing a comparator per LUT input.
    localparam int POOL_EXT = 1 << SEL_W;

    logic [CFG_BITS-1:0]  chain;
    logic [NUM_CELLS-1:0] q;
    logic [NUM_CELLS-1:0] lut_out;
    logic [NUM_CELLS-1:0] reg_en;
    logic [CNT_W-1:0]     cnt;
    logic                 cfg_en_d;
    logic [POOL_EXT-1:0]  pool;

    // Routing pool: din first, then the registered cell outputs. Only q
    // feeds back, so no combinational loop can be configured.
    always_comb begin
        pool           = '0;
        pool[POOL-1:0] = {q, din};
    end

    // Cell LUTs and input routing.
    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
        logic [CW-1:0]    field;
        logic [TT-1:0]    truth;
        logic [LUT_K-1:0] lut_idx;

        assign field = chain[i*CW +: CW];
        assign truth = field[TT-1:0];

        for (genvar j = 0; j < LUT_K; j++) begin : g_in
            logic [SEL_W-1:0] sel;
            assign sel        = field[TT+1+j*SEL_W +: SEL_W];
            assign lut_idx[j] = pool[sel];
        end

        assign reg_en[i]  = field[TT];
        assign lut_out[i] = truth[lut_idx];
    end

    // Config chain: first bit shifted in ends up in the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else if (cfg_en) begin
            chain <= {chain[CFG_BITS-2:0], cfg_data};
        end
    end

    // Cell flip-flops: cleared while configuring so a freshly loaded design
    // always starts from a known all-zero register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (cfg_en) begin
            q <= '0;
        end else if (ce) begin
            q <= lut_out;
        end
    end

    // Load-length check. The counter saturates one past CFG_BITS so long
    // loads never wrap back onto the "exact" value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            cfg_en_d <= 1'b0;
            cfg_ok   <= 1'b0;
        end else begin
            cfg_en_d <= cfg_en;
            if (cfg_en) begin
                if (cnt != CNT_W'(CFG_BITS + 1)) begin
                    cnt <= cnt + 1'b1;
                end
            end else if (cfg_en_d) begin
                cfg_ok <= (cnt == CNT_W'(CFG_BITS));
                cnt    <= '0;
            end
        end
    end

    // Output mux; combinational cells give a zero-latency din->dout path.
    assign dout = cfg_en ? '0 : ((reg_en & q) | (~reg_en & lut_out));

endmodule

// File: tb/tb_minilogix_cell_array.sv
// tb/tb_minilogix_cell_array.sv - self-checking bench for minilogix_cell_array

module tb_minilogix_cell_array;

    localparam int NI = 8;
    localparam int NC = 8;
    localparam int CW = 21;
    localparam int CB = 168;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_en;
    logic          cfg_data;
    logic          ce;
    logic [NI-1:0] din;
    logic [NC-1:0] dout;
    logic          cfg_ok;

    always #5 clk = ~clk;

    minilogix_cell_array #(.NUM_IN(NI), .NUM_CELLS(NC), .LUT_K(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_en  (cfg_en),
        .cfg_data(cfg_data),
        .ce      (ce),
        .din     (din),
        .dout    (dout),
        .cfg_ok  (cfg_ok)
    );

    typedef struct {
        string      name;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic sb_check(input string name);
        if (sb.size() == 0) chk({name, "_sb_empty"}, 32'd1, 32'd0);
        else chk(name, {24'd0, dout}, {24'd0, sb.pop_front()});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CB-1:0] cell_set(input logic [CB-1:0] base, input int idx,
                                               input logic [7:0] truth, input logic ren,
                                               input logic [3:0] s0, input logic [3:0] s1,
                                               input logic [3:0] s2);
        logic [CB-1:0] r;
        r = base;
        r[idx*CW +: CW] = {s2, s1, s0, ren, truth};
        return r;
    endfunction

    // Shifts v[n-1] first down to v[0], then drops cfg_en for one edge so
    // cfg_ok is valid on return.
    task automatic load(input logic [CB:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cfg_en   = 1'b1;
            cfg_data = v[i];
            step();
        end
        cfg_en   = 1'b0;
        cfg_data = 1'b0;
        step();
    endtask

    task automatic run_vecs(input vec_t v[4]);
        for (int i = 0; i < 4; i++) begin
            din = v[i].din;
            sb.push_back(v[i].exp);
            #2;
            sb_check(v[i].name);
            step();
        end
    endtask

    logic [CB-1:0] cfg_inv, cfg_tog, cfg_cnt;
    vec_t          post_rst[4];
    vec_t          inv_vec[4];
    logic          eq;
    logic [1:0]    ecnt;

    initial begin
        post_rst[0] = '{"idle_a5", 8'hA5, 8'h00};
        post_rst[1] = '{"idle_ff", 8'hFF, 8'h00};
        post_rst[2] = '{"idle_00", 8'h00, 8'h00};
        post_rst[3] = '{"idle_3c", 8'h3C, 8'h00};
        inv_vec[0]  = '{"inv_ff", 8'hFF, 8'h00};
        inv_vec[1]  = '{"inv_00", 8'h00, 8'h01};
        inv_vec[2]  = '{"inv_fe", 8'hFE, 8'h01};
        inv_vec[3]  = '{"inv_01", 8'h01, 8'h00};

        cfg_inv = cell_set('0, 0, 8'h55, 1'b0, 4'd0, 4'd0, 4'd0);
        cfg_tog = cell_set('0, 0, 8'h55, 1'b1, 4'd8, 4'd0, 4'd0);
        cfg_cnt = cell_set(cfg_tog, 1, 8'h66, 1'b1, 4'd8, 4'd9, 4'd0);

        rst_n    = 1'b0;
        cfg_en   = 1'b0;
        cfg_data = 1'b0;
        ce       = 1'b0;
        din      = 8'($urandom);
        step();
        step();
        chk("rst_dout", {24'd0, dout}, 32'd0);
        chk("rst_cfg_ok", {31'd0, cfg_ok}, 32'd0);
        rst_n = 1'b1;
        step();
        run_vecs(post_rst);

        // Combinational inverter on din[0].
        load({1'b0, cfg_inv}, CB);
        chk("inv_cfg_ok", {31'd0, cfg_ok}, 32'd1);
        run_vecs(inv_vec);

        // Toggle flip-flop feeding back q[0].
        load({1'b0, cfg_tog}, CB);
        chk("tog_cfg_ok", {31'd0, cfg_ok}, 32'd1);
        ce = 1'b1;
        eq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sb.push_back({7'd0, eq});
            #2;
            sb_check($sformatf("tog_%0d", i));
            step();
            eq = ~eq;
        end
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back({7'd0, eq});
            #2;
            sb_check($sformatf("tog_hold_%0d", i));
            step();
        end
        // q[0] is 1 here; a config pass must clear it even with ce low.
        load({1'b0, cfg_tog}, CB);
        sb.push_back(8'h00);
        sb_check("tog_cleared");
        chk("tog2_cfg_ok", {31'd0, cfg_ok}, 32'd1);

        // Two-bit counter: q0 toggles, q1 <= q0 ^ q1.
        load({1'b0, cfg_cnt}, CB);
        chk("cnt_cfg_ok", {31'd0, cfg_ok}, 32'd1);
        ce   = 1'b1;
        ecnt = 2'd0;
        for (int i = 0; i < 6; i++) begin
            sb.push_back({6'd0, ecnt});
            #2;
            sb_check($sformatf("cnt_%0d", i));
            step();
            ecnt = ecnt + 2'd1;
        end
        ce = 1'b0;

        // Length checks, back to back with one idle cycle between loads.
        load({1'b0, cfg_inv}, CB - 1);
        chk("short_cfg_ok", {31'd0, cfg_ok}, 32'd0);
        load({1'b1, cfg_inv}, CB + 1);
        chk("long_cfg_ok", {31'd0, cfg_ok}, 32'd0);
        din = 8'h00;
        sb.push_back(8'h01);
        #2;
        sb_check("long_inv_0");
        din = 8'h01;
        sb.push_back(8'h00);
        #2;
        sb_check("long_inv_1");
        load({1'b0, cfg_inv}, CB);
        chk("exact_cfg_ok", {31'd0, cfg_ok}, 32'd1);

        // Reset in the middle of a load.
        for (int i = CB - 1; i >= CB - 100; i--) begin
            cfg_en   = 1'b1;
            cfg_data = cfg_inv[i];
            step();
        end
        cfg_en = 1'b0;
        din    = 8'h00;
        rst_n  = 1'b0;
        #2;
        chk("midrst_cfg_ok", {31'd0, cfg_ok}, 32'd0);
        sb.push_back(8'h00);
        sb_check("midrst_dout");
        step();
        rst_n = 1'b1;
        step();
        sb.push_back(8'h00);
        sb_check("midrst_after");
        load({1'b0, cfg_inv}, CB);
        chk("midrst_reload_ok", {31'd0, cfg_ok}, 32'd1);
        din = 8'h00;
        sb.push_back(8'h01);
        #2;
        sb_check("midrst_inv");

        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
